stream_decipher: RTL and testbench
==================================

# stream_decipher

Receive-side companion to the byte-wide stream cipher: it accepts a framed ciphertext byte stream, recovers the per-frame seed from the header, regenerates the identical 16-bit Galois-LFSR keystream, and emits plaintext bytes through a valid/ready output. A trailing XOR checksum is verified for each frame. It sits between the ciphertext input pins/deserializer and the plaintext consumer, and is the decrypt end of the cipher link.

## Interface

Parameters:

- `SYNC`, 8'hA5, frame start byte searched for in HUNT
- `TAPS`, 16'hB400, Galois feedback polynomial mask
- `DEF_SEED`, 16'hACE1, substituted when the received seed is 16'h0000

Ports:

- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `ena`  in  1  input enable; low blocks input acceptance
- `in_data`  in  8  ciphertext/header byte
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  byte accepted when `in_valid & in_ready`
- `out_data`  out  8  plaintext byte
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer takes byte when `out_valid & out_ready`
- `frame_done`  out  1  one-cycle pulse, frame ended with a correct checksum
- `frame_err`  out  1  one-cycle pulse, frame ended with a checksum mismatch
- `busy`  out  1  high in any state other than HUNT

## Operation

- Frame format: `SYNC`, seed[15:8], seed[7:0], LEN (0–255), LEN ciphertext bytes, CHK.
- CHK is the XOR of all plaintext bytes. It is sent in the clear.
- State machine: HUNT → SEED_HI → SEED_LO → LENGTH → DATA → CHECK → HUNT.
  - HUNT: non-`SYNC` bytes are accepted and discarded. `SYNC` moves to SEED_HI.
  - SEED_LO: loads `lfsr = {hi, lo}`; if the value is 0, loads `DEF_SEED`. Clears `chk_acc`.
  - LENGTH: stores `cnt = LEN`. If LEN=0, goes directly to CHECK.
  - DATA: for each accepted byte:
    - plaintext = `in_data ^ lfsr[7:0]`, written to the output register;
    - `chk_acc ^= plaintext`;
    - LFSR advanced 8 Galois steps in one cycle (each step: `fb = s[0]; s = s >> 1; if fb then s ^= TAPS`);
    - `cnt` decrements; the byte that brings `cnt` to 0 moves the FSM to CHECK.
  - CHECK: the accepted byte is compared with `chk_acc`; pulses `frame_done` or `frame_err`; returns to HUNT.
- A `SYNC` value inside DATA or CHECK is treated as data. There is no mid-frame resync.
- `in_ready` = `ena` in HUNT/SEED_HI/SEED_LO/LENGTH/CHECK.
- `in_ready` = `ena & (!out_valid | out_ready)` in DATA, so the single output register never overflows.
- `ena` low: no input acceptance and FSM state is frozen. The output register still drains via `out_ready`.
- The output register holds `out_data` and `out_valid` stable until taken.

## Timing

- Reset values: state=HUNT, `out_valid`=0, `out_data`=8'h00, `frame_done`=0, `frame_err`=0, `busy`=0, `lfsr`=`DEF_SEED`, `cnt`=0, `chk_acc`=0.
- `in_ready` is combinational from state, `ena`, `out_valid`, and `out_ready`. It is 0 while `rst` is high.
- Latency: a DATA byte accepted at edge N gives `out_valid`=1 with plaintext from edge N (visible in cycle N+1).
- Throughput: one byte per cycle when `out_ready` is held high.
- Simultaneous take and accept in DATA: the output register is reloaded in the same edge and `out_valid` stays 1.
- `frame_done`/`frame_err` assert in the cycle after the CHK byte handshake, last one cycle, and are mutually exclusive.
- CHK byte handshake ordering: `frame_done`/`frame_err` may pulse while the final plaintext byte is still pending in the output register; that byte is not lost.
- Reset mid-frame: next cycle state=HUNT and `out_valid`=0. A pending output byte is dropped and no frame pulse is emitted.
- The byte accepted in the cycle after CHECK is evaluated in HUNT. Back-to-back frames need no idle gap.

## Test plan

- Frame A5 12 34 01 (0x55^0x34=0x61) 0x55 → `out_data`=0x61 one cycle after accept; then CHK 0x61 → `frame_done` pulse; `busy` returns to 0.
- Same frame with CHK 0x60 → `frame_err` pulses once, no `frame_done`; the next frame decodes correctly.
- Garbage 00 FF 5A, then A5 00 00 00 00 → garbage is ignored; seed 0 selects `DEF_SEED`; LEN=0 with CHK 00 → `frame_done`.
- 16-byte frame with seed 0xBEEF, ciphertext built by a bench reference LFSR model, `out_ready` toggled pseudo-randomly → all plaintext bytes match in order; `in_ready` is low whenever output is full and not taken; `frame_done` pulses.
- `ena` deasserted for 5 cycles mid-DATA → no bytes accepted, state held, pending output still drains; decoding resumes correctly.
- Assert `rst` after the 3rd DATA byte → `out_valid`=0 and `busy`=0 next cycle, no frame pulse; a new full frame then decodes correctly.

Source files
------------

// File: rtl/stream_decipher.sv
// Receive-side stream decipher: finds a frame by its sync byte, recovers the
// per-frame seed and regenerates the 16-bit Galois LFSR keystream. Plaintext
// leaves through a single valid/ready output register, and the trailing XOR
// checksum of each frame is verified.
module stream_decipher #(
    parameter logic [7:0]  SYNC     = 8'hA5,
    parameter logic [15:0] TAPS     = 16'hB400,
    parameter logic [15:0] DEF_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        StHunt,
        StSeedHi,
        StSeedLo,
        StLength,
        StData,
        StCheck
    } state_e;

    // Eight Galois steps folded into one cycle, so one key byte is used per data byte.
    function automatic logic [15:0] lfsr_adv8(input logic [15:0] s);
        logic [15:0] t;
        t = s;
        for (int i = 0; i < 8; i++) begin
            if (t[0]) begin
                t = (t >> 1) ^ TAPS;
            end else begin
                t = t >> 1;
            end
        end
        return t;
    endfunction

    state_e      state_q, state_d;
    logic [7:0]  seed_hi_q, seed_hi_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        accept;
    logic        take;
    logic [7:0]  plain;
    logic [15:0] lfsr_next;
    logic [15:0] seed_rx;

    assign take      = out_valid_q & out_ready;
    assign accept    = in_valid & in_ready;
    assign lfsr_next = lfsr_adv8(lfsr_q);
    assign plain     = in_data ^ lfsr_q[7:0];
    assign seed_rx   = {seed_hi_q, in_data};

    // Input acceptance: in DATA a byte may only enter if the output register has room
    // this cycle (empty or being taken).
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state_q == StData) begin
                in_ready = ena & (~out_valid_q | out_ready);
            end else begin
                in_ready = ena;
            end
        end
    end

    // Next-state, datapath updates and frame result pulses.
    always_comb begin
        state_d     = state_q;
        seed_hi_d   = seed_hi_q;
        lfsr_d      = lfsr_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        out_data_d  = out_data_q;
        out_valid_d = take ? 1'b0 : out_valid_q;
        done_d      = 1'b0;
        err_d       = 1'b0;

        if (accept) begin
            unique case (state_q)
                StHunt: begin
                    if (in_data == SYNC) begin
                        state_d = StSeedHi;
                    end
                end
                StSeedHi: begin
                    seed_hi_d = in_data;
                    state_d   = StSeedLo;
                end
                StSeedLo: begin
                    // An all-zero seed would lock the LFSR, so substitute the default.
                    lfsr_d  = (seed_rx == 16'h0000) ? DEF_SEED : seed_rx;
                    chk_d   = 8'h00;
                    state_d = StLength;
                end
                StLength: begin
                    cnt_d   = in_data;
                    state_d = (in_data == 8'h00) ? StCheck : StData;
                end
                StData: begin
                    out_data_d  = plain;
                    out_valid_d = 1'b1;
                    chk_d       = chk_q ^ plain;
                    lfsr_d      = lfsr_next;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StCheck;
                    end
                end
                StCheck: begin
                    if (in_data == chk_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = StHunt;
                end
                default: begin
                    state_d = StHunt;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StHunt;
            seed_hi_q   <= 8'h00;
            lfsr_q      <= DEF_SEED;
            cnt_q       <= 8'h00;
            chk_q       <= 8'h00;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_hi_q   <= seed_hi_d;
            lfsr_q      <= lfsr_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != StHunt);

endmodule

// File: tb/tb_stream_decipher.sv
// Randomised bench for stream_decipher: frames are built from plaintext with a
// behavioural keystream model, and outputs are scoreboarded against a queue.
module tb_stream_decipher;

    logic       clk;
    logic       rst;
    logic       ena;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_done;
    logic       frame_err;
    logic       busy;

    int n_total = 0;
    int n_bad   = 0;
    int n_done  = 0;
    int n_err   = 0;
    int exp_done = 0;
    int exp_err  = 0;
    int mode = 0;  // out_ready policy: 0 always, 1 random, 2 never

    logic [7:0] exp_q[$];
    bit         prev_hold = 0;
    logic [7:0] prev_data = 8'h00;

    stream_decipher dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Keystream model: next 16-bit state after one byte's worth of Galois shifts.
    function automatic logic [15:0] ks_next(input logic [15:0] s);
        logic [15:0] v;
        v = s;
        for (int k = 0; k < 8; k++) begin
            v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
        end
        return v;
    endfunction

    // Output side: drive out_ready per policy, then scoreboard what the DUT hands over.
    always @(negedge clk) begin
        case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        #1;
        if (rst) begin
            prev_hold = 0;
        end else begin
            if (prev_hold) begin
                check_eq("hold_valid", out_valid, 1);
                check_eq("hold_data", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("out_extra", out_valid, 0);
                end else begin
                    check_eq("out_data", out_data, exp_q.pop_front());
                end
            end
            if (frame_done) n_done++;
            if (frame_err) n_err++;
            if (frame_done || frame_err) check_eq("pulse_excl", frame_done & frame_err, 0);
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
        end
    end

    // Present one byte until accepted; checks in_ready every cycle it waits.
    task automatic send_byte(input logic [7:0] b, input bit is_data);
        int    waited;
        bit    done;
        string tag;
        waited = 0;
        done   = 0;
        tag    = is_data ? "in_ready_data" : "in_ready_ctl";
        while (!done) begin
            @(negedge clk);
            in_data  = b;
            in_valid = 1'b1;
            #2;
            check_eq(tag, in_ready, is_data ? (ena & (~out_valid | out_ready)) : ena);
            if (in_ready) begin
                done = 1;
            end else begin
                waited++;
                if (waited > 200) begin
                    check_eq("accept_timeout", waited, 200);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Hold a data byte offered with ena low for five cycles; nothing may be accepted.
    task automatic ena_gap(input logic [7:0] b);
        int saved;
        saved = mode;
        mode  = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ena      = 1'b0;
            in_data  = b;
            in_valid = 1'b1;
            #2;
            check_eq("gap_in_ready", in_ready, 0);
            check_eq("gap_busy", busy, 1);
        end
        check_eq("gap_drained", out_valid, 0);
        in_valid = 1'b0;
        ena      = 1'b1;
        mode     = saved;
    endtask

    task automatic reset_mid();
        mode = 2;
        @(negedge clk);
        rst = 1'b1;
        #2;
        check_eq("rst_in_ready", in_ready, 0);
        @(negedge clk);
        #2;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_in_ready2", in_ready, 0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        mode = 1;
    endtask

    task automatic send_frame(input logic [15:0] seed, input int len, input int fixed_pt,
                              input logic [7:0] flip, input int gap_at, input int abort_after);
        logic [7:0]  pts[$];
        logic [15:0] s;
        logic [7:0]  chk;
        logic [7:0]  p;
        logic [7:0]  ct;
        logic [7:0]  lenb;
        chk  = 8'h00;
        lenb = len[7:0];
        s    = (seed == 16'h0000) ? 16'hACE1 : seed;
        for (int i = 0; i < len; i++) begin
            p = (fixed_pt >= 0) ? fixed_pt[7:0] : 8'($urandom);
            pts.push_back(p);
            exp_q.push_back(p);
            chk ^= p;
        end
        send_byte(8'hA5, 0);
        check_eq("busy_hdr", busy, 1);
        send_byte(seed[15:8], 0);
        send_byte(seed[7:0], 0);
        send_byte(lenb, 0);
        for (int i = 0; i < len; i++) begin
            ct = pts[i] ^ s[7:0];
            if (i == gap_at) ena_gap(ct);
            send_byte(ct, 1);
            check_eq("lat_valid", out_valid, 1);
            check_eq("lat_data", out_data, pts[i]);
            s = ks_next(s);
            if (i + 1 == abort_after) begin
                reset_mid();
                return;
            end
        end
        send_byte(chk ^ flip, 0);
        check_eq("frame_done", frame_done, (flip == 8'h00));
        check_eq("frame_err", frame_err, (flip != 8'h00));
        check_eq("busy_end", busy, 0);
        if (flip == 8'h00) exp_done++;
        else exp_err++;
    endtask

    initial begin
        logic [7:0] g;
        logic [15:0] sd;
        rst       = 1'b1;
        ena       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", out_data, 8'h00);
        check_eq("reset_done", frame_done, 0);
        check_eq("reset_err", frame_err, 0);
        check_eq("reset_busy", busy, 0);
        rst = 1'b0;

        // Known-answer frame: A5 12 34 01 55 61.
        mode = 0;
        send_frame(16'h1234, 1, 8'h61, 8'h00, -1, -1);
        // Same frame with a bad checksum (0x60), then a clean random frame.
        send_frame(16'h1234, 1, 8'h61, 8'h01, -1, -1);
        send_frame(16'($urandom), 6, -1, 8'h00, -1, -1);

        // Garbage in HUNT, then zero seed with zero length.
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        check_eq("hunt_busy", busy, 0);
        send_frame(16'h0000, 0, -1, 8'h00, -1, -1);
        // Zero seed with data exercises the default-seed keystream.
        send_frame(16'h0000, 5, -1, 8'h00, -1, -1);

        // Long frame under random backpressure.
        mode = 1;
        send_frame(16'hBEEF, 16, -1, 8'h00, -1, -1);
        // ena gap in the middle of DATA.
        send_frame(16'($urandom), 10, -1, 8'h00, 4, -1);
        // Reset after the third data byte, then a full frame.
        send_frame(16'($urandom), 16, -1, 8'h00, -1, 3);
        send_frame(16'($urandom), 8, -1, 8'h00, -1, -1);

        // Random back-to-back frames with occasional garbage and bad checksums.
        for (int f = 0; f < 24; f++) begin
            mode = int'($urandom_range(0, 1));
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h3C;
                send_byte(g, 0);
                check_eq("garbage_busy", busy, 0);
            end
            sd = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
            send_frame(sd, int'($urandom_range(0, 12)), -1,
                       ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                       -1, -1);
        end

        mode = 0;
        repeat (6) @(negedge clk);
        #3;
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("done_count", n_done, exp_done);
        check_eq("err_count", n_err, exp_err);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
